// File: rtl/alu_seq_unit.sv
// Clocked ALU: ADD/SUB/CMP/AND/OR/XOR in one cycle, shift-add MUL over WIDTH cycles,
// with valid/ready handshakes on operands and on the held result.
module alu_seq_unit #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               a_gt_b,
  output logic               a_eq_b,
  output logic               a_lt_b,
  output logic               zero,
  output logic               op_err
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_CMP = 3'd2, OP_AND = 3'd3,
                         OP_OR  = 3'd4, OP_XOR = 3'd5, OP_MUL = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;

  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic               is_sub;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] r;
  logic               c, gt, eq, lt, err;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // SUB shares the adder: a + ~b + 1, so carry-out doubles as no-borrow
  assign is_sub = (op == OP_SUB);
  assign addend = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    r   = '0;
    c   = 1'b0;
    gt  = 1'b0;
    eq  = 1'b0;
    lt  = 1'b0;
    err = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        r[WIDTH-1:0] = sum[WIDTH-1:0];
        c            = sum[WIDTH];
      end
      OP_CMP: begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
      end
      OP_AND:  r[WIDTH-1:0] = a & b;
      OP_OR:   r[WIDTH-1:0] = a | b;
      OP_XOR:  r[WIDTH-1:0] = a ^ b;
      OP_MUL:  r = '0;
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      carry  <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
      zero   <= 1'b0;
      op_err <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (op == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end else begin
            result <= r;
            carry  <= c;
            a_gt_b <= gt;
            a_eq_b <= eq;
            a_lt_b <= lt;
            zero   <= (r == '0);
            op_err <= err;
            state  <= DONE;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            result <= acc_nxt;
            carry  <= 1'b0;
            a_gt_b <= 1'b0;
            a_eq_b <= 1'b0;
            a_lt_b <= 1'b0;
            zero   <= (acc_nxt == '0);
            op_err <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit at WIDTH=8.
module tb_alu_seq_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic        carry, a_gt_b, a_eq_b, a_lt_b, zero, op_err;
  int          n_chk = 0, n_pass = 0;

  // {in_ready, out_valid, result, carry, gt, eq, lt, zero, op_err}
  logic [23:0] obs;
  assign obs = {in_ready, out_valid, result, carry, a_gt_b, a_eq_b, a_lt_b, zero, op_err};

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .zero(zero),
    .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    step(); step();
    rst_n = 1'b1;
    n_chk++;
    if (obs !== 24'h800000) $display("FAIL reset obs=%h exp=%h", obs, 24'h800000);
    else n_pass++;
  endtask

  task automatic test_add;
    issue(3'd0, 8'hF0, 8'h20);
    n_chk++;
    if (obs !== {2'b01, 16'h0010, 6'b100000}) $display("FAIL add obs=%h exp=%h", obs, {2'b01, 16'h0010, 6'b100000});
    else n_pass++;
    drain();
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL add_drain rdy/vld=%b exp=10", {in_ready, out_valid});
    else n_pass++;
  endtask

  task automatic test_sub;
    issue(3'd1, 8'h05, 8'h07);
    n_chk++;
    if (obs !== {2'b01, 16'h00FE, 6'b000000}) $display("FAIL sub_borrow obs=%h exp=%h", obs, {2'b01, 16'h00FE, 6'b000000});
    else n_pass++;
    drain();
    issue(3'd1, 8'h07, 8'h07);
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b100010}) $display("FAIL sub_eq obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b100010});
    else n_pass++;
    drain();
  endtask

  task automatic test_cmp;
    issue(3'd2, 8'h33, 8'h12);
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b010010}) $display("FAIL cmp_gt obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b010010});
    else n_pass++;
    drain();
    issue(3'd2, 8'h44, 8'h44);
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b001010}) $display("FAIL cmp_eq obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b001010});
    else n_pass++;
    drain();
    issue(3'd2, 8'h01, 8'h80);
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b000110}) $display("FAIL cmp_lt obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b000110});
    else n_pass++;
    drain();
  endtask

  task automatic test_logic;
    issue(3'd4, 8'hA5, 8'h0F);
    n_chk++;
    if (obs !== {2'b01, 16'h00AF, 6'b000000}) $display("FAIL or obs=%h exp=%h", obs, {2'b01, 16'h00AF, 6'b000000});
    else n_pass++;
    drain();
    issue(3'd5, 8'hFF, 8'hFF);
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b000010}) $display("FAIL xor obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b000010});
    else n_pass++;
    drain();
  endtask

  task automatic test_mul;
    logic ok;
    ok = 1'b1;
    issue(3'd6, 8'hFF, 8'hFF);
    for (int i = 1; i <= 8; i++) begin
      if ({in_ready, out_valid} !== 2'b00) ok = 1'b0;
      step();
    end
    n_chk++;
    if (!ok) $display("FAIL mul_busy in_ready/out_valid not low for cycles 1..8");
    else n_pass++;
    n_chk++;
    if (obs !== {2'b01, 16'hFE01, 6'b000000}) $display("FAIL mul_ff obs=%h exp=%h", obs, {2'b01, 16'hFE01, 6'b000000});
    else n_pass++;
    drain();
    issue(3'd6, 8'h00, 8'h5A);
    for (int i = 1; i <= 8; i++) step();
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b000010}) $display("FAIL mul_zero obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b000010});
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back;
    logic ok;
    ok = 1'b1;
    issue(3'd3, 8'hCC, 8'hAA);
    op = 3'd0; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (obs !== {2'b01, 16'h0088, 6'b000000}) ok = 1'b0;
      step();
    end
    n_chk++;
    if (!ok || obs !== {2'b01, 16'h0088, 6'b000000})
      $display("FAIL and_hold obs=%h exp=%h", obs, {2'b01, 16'h0088, 6'b000000});
    else n_pass++;
    drain();
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_idle rdy/vld=%b exp=10", {in_ready, out_valid});
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_chk++;
    if (obs !== {2'b01, 16'h0003, 6'b000000}) $display("FAIL bp_second obs=%h exp=%h", obs, {2'b01, 16'h0003, 6'b000000});
    else n_pass++;
    drain();
  endtask

  task automatic test_err_and_abort;
    logic ok;
    issue(3'd7, 8'h12, 8'h34);
    n_chk++;
    if (obs !== {2'b01, 16'h0000, 6'b000011}) $display("FAIL op_err obs=%h exp=%h", obs, {2'b01, 16'h0000, 6'b000011});
    else n_pass++;
    drain();
    issue(3'd6, 8'hFF, 8'hFF);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++;
    if (obs !== 24'h800000) $display("FAIL mul_abort obs=%h exp=%h", obs, 24'h800000);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) ok = 1'b0;
      step();
    end
    n_chk++;
    if (!ok) $display("FAIL abort_no_pulse out_valid=1 exp=0");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_logic();
    test_mul();
    test_back_to_back();
    test_err_and_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
